cs_window_filter: RTL and testbench

CS_WINDOW_FILTER -- requirements
Module: cs_window_filter

---
 rtl/cs_pkg.sv | 26 ++
 rtl/cs_approx_sel.sv | 25 ++
 rtl/cs_window_filter.sv | 130 +++++++++++++
 tb/tb_cs_window_filter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cs_pkg.sv
// Shared definitions for the cs_window_filter block: default sizes, FSM states
// and a constant-evaluable ceiling log2.
package cs_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_N  = 9;
    localparam int DEF_SH = 3;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        int p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p * 2;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cs_approx_sel.sv
// Combinational search for the largest window entry not exceeding the average.
// Equal values are interchangeable, so scan order does not matter.
module cs_approx_sel
    import cs_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int N  = DEF_N
) (
    input  logic [DW-1:0]           win [N],
    input  logic [DW+clog2(N)-1:0]  avg,
    output logic [DW-1:0]           xappr
);

    localparam int AW = DW + clog2(N);

    always_comb begin
        xappr = '0;
        for (int i = 0; i < N; i++) begin
            if ((AW'(win[i]) <= avg) && (win[i] > xappr)) begin
                xappr = win[i];
            end
        end
    end

endmodule

// File: rtl/cs_window_filter.sv
// N-deep sliding-window filter: running sum, floor mean, and an approximate
// filter mixing the sum with the largest sample not above the mean.
module cs_window_filter
    import cs_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int N  = DEF_N,
    parameter int SH = DEF_SH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      mode,
    input  logic                      in_valid,
    input  logic [DW-1:0]             X,
    output logic                      out_valid,
    output logic [DW+clog2(N)-SH:0]   Y
);

    localparam int SW = DW + clog2(N);
    localparam int OW = DW + clog2(N) + 1 - SH;
    localparam int CW = clog2(N + 1);

    logic [DW-1:0] win_p0 [N];
    logic [SW-1:0] sum_p0;
    logic [CW-1:0] cnt_p0;
    state_t        state_p0;

    logic [DW-1:0] nwin [N];
    logic [SW-1:0] nsum;
    logic [SW-1:0] avg;
    logic [DW-1:0] xappr;
    logic [CW-1:0] cnt_nx;
    state_t        state_nx;
    logic          full_nx;

    logic [OW-1:0] y_p1;
    logic          vld_p1;

    // Sum and N*Xappr are added at SW+1 bits so the shift sees the exact value.
    function automatic logic [OW-1:0] mix_fn(input logic [SW-1:0] s, input logic [DW-1:0] xa);
        logic [SW:0] t;
        t = (SW+1)'(s) + (SW+1)'(N) * (SW+1)'(xa);
        return OW'(t >> SH);
    endfunction

    function automatic logic [OW-1:0] mean_fn(input logic [SW-1:0] a);
        return OW'(a);
    endfunction

    // Stage p0 -> p1: window as it will look after the incoming sample.
    always_comb begin
        nwin[0] = X;
        for (int i = 1; i < N; i++) begin
            nwin[i] = win_p0[i-1];
        end
        nsum = sum_p0 - SW'(win_p0[N-1]) + SW'(X);
        avg  = nsum / SW'(N);
    end

    cs_approx_sel #(
        .DW (DW),
        .N  (N)
    ) u_sel (
        .win   (nwin),
        .avg   (avg),
        .xappr (xappr)
    );

    always_comb begin
        state_nx = state_p0;
        cnt_nx   = cnt_p0;
        full_nx  = 1'b0;
        if (flush) begin
            state_nx = FILL;
            cnt_nx   = '0;
        end else if (in_valid) begin
            case (state_p0)
                FILL: begin
                    cnt_nx = cnt_p0 + CW'(1);
                    if (cnt_p0 == CW'(N - 1)) begin
                        state_nx = RUN;
                        full_nx  = 1'b1;
                    end
                end
                RUN: begin
                    full_nx = 1'b1;
                end
                default: begin
                    state_nx = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p0 <= FILL;
            cnt_p0   <= '0;
            sum_p0   <= '0;
            for (int i = 0; i < N; i++) begin
                win_p0[i] <= '0;
            end
            y_p1     <= '0;
            vld_p1   <= 1'b0;
        end else begin
            state_p0 <= state_nx;
            cnt_p0   <= cnt_nx;
            vld_p1   <= full_nx;
            if (flush) begin
                sum_p0 <= '0;
                for (int i = 0; i < N; i++) begin
                    win_p0[i] <= '0;
                end
            end else if (in_valid) begin
                sum_p0 <= nsum;
                for (int i = 0; i < N; i++) begin
                    win_p0[i] <= nwin[i];
                end
            end
            if (full_nx) begin
                y_p1 <= mode ? mean_fn(avg) : mix_fn(nsum, xappr);
            end
        end
    end

    assign out_valid = vld_p1;
    assign Y         = y_p1;

endmodule

// File: tb/tb_cs_window_filter.sv
// Bench for cs_window_filter: directed scenarios plus random traffic, checked
// against a queue-based model of the most recent accepted samples.
module tb_cs_window_filter;
    import cs_pkg::*;

    localparam int DW = 8;
    localparam int N  = 9;
    localparam int SH = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          mode;
    logic          in_valid;
    logic [DW-1:0] X;
    logic          out_valid;
    logic [9:0]    Y;

    int checks   = 0;
    int failures = 0;

    int unsigned hist[$];
    int unsigned exp_y   = 0;
    bit          exp_vld = 1'b0;

    cs_window_filter #(.DW(DW), .N(N), .SH(SH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .mode      (mode),
        .in_valid  (in_valid),
        .X         (X),
        .out_valid (out_valid),
        .Y         (Y)
    );

    always #5 clk = ~clk;

    function automatic int unsigned ref_y(bit m);
        int unsigned s;
        int unsigned avg;
        int unsigned best;
        s = 0;
        best = 0;
        foreach (hist[i]) s += hist[i];
        avg = s / N;
        foreach (hist[i]) if (hist[i] <= avg && hist[i] > best) best = hist[i];
        return m ? avg : (s + N * best) >> SH;
    endfunction

    task automatic drive(bit v, int unsigned x, bit m, bit f);
        @(negedge clk);
        in_valid = v;
        X        = x[DW-1:0];
        mode     = m;
        flush    = f;
        @(posedge clk);
        if (f) begin
            hist.delete();
            exp_vld = 1'b0;
        end else if (v) begin
            hist.push_back(x & 32'hFF);
            if (hist.size() > N) void'(hist.pop_front());
            exp_vld = (hist.size() == N);
            if (exp_vld) exp_y = ref_y(m);
        end else begin
            exp_vld = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; mode = 1'b0; in_valid = 1'b0; X = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (Y !== 10'd0 || out_valid !== 1'b0 || dut.state_p0 !== FILL) begin
            failures++;
            $display("FAIL reset: y=%0d vld=%0b state=%0d, expected y=0 vld=0 state=FILL", Y, out_valid, dut.state_p0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fill_run();
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, k, 1'b0, 1'b0);
            checks++;
            if (out_valid !== exp_vld || Y !== exp_y[9:0]) begin
                failures++;
                $display("FAIL fill_run[%0d]: y=%0d vld=%0b, expected y=%0d vld=%0b", k, Y, out_valid, exp_y, exp_vld);
            end
            if (k == 9 || k == 10) begin
                checks++;
                if (Y !== ((k == 9) ? 10'd11 : 10'd13) || out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL fill_run_known[%0d]: y=%0d vld=%0b, expected y=%0d vld=1", k, Y, out_valid, (k == 9) ? 11 : 13);
                end
            end
        end
    endtask

    task automatic test_bubbles();
        drive(1'b0, 0, 1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, k, 1'b0, 1'b0);
            checks++;
            if (out_valid !== exp_vld || Y !== exp_y[9:0]) begin
                failures++;
                $display("FAIL bubbles_sample[%0d]: y=%0d vld=%0b, expected y=%0d vld=%0b", k, Y, out_valid, exp_y, exp_vld);
            end
            for (int g = 0; g < 3; g++) begin
                drive(1'b0, $urandom_range(255), 1'(g), 1'b0);
                checks++;
                if (out_valid !== 1'b0 || Y !== exp_y[9:0]) begin
                    failures++;
                    $display("FAIL bubbles_gap[%0d]: y=%0d vld=%0b, expected y=%0d vld=0", k, Y, out_valid, exp_y);
                end
            end
        end
    endtask

    task automatic test_mode1_sat();
        drive(1'b0, 0, 1'b0, 1'b1);
        for (int k = 1; k <= 9; k++) drive(1'b1, k, 1'b1, 1'b0);
        checks++;
        if (Y !== 10'd5 || out_valid !== 1'b1 || exp_y != 5) begin
            failures++;
            $display("FAIL mode1_mean: y=%0d vld=%0b, expected y=5 vld=1", Y, out_valid);
        end
        for (int k = 1; k <= 9; k++) drive(1'b1, 255, 1'b0, 1'b0);
        checks++;
        if (Y !== 10'd573 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL saturation_255: y=%0d vld=%0b, expected y=573 vld=1", Y, out_valid);
        end
    endtask

    task automatic test_flush();
        drive(1'b0, 0, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) drive(1'b1, $urandom_range(255), 1'b0, 1'b0);
        drive(1'b1, 200, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || Y !== exp_y[9:0]) begin
            failures++;
            $display("FAIL flush_cycle: y=%0d vld=%0b, expected y=%0d vld=0", Y, out_valid, exp_y);
        end
        for (int k = 1; k <= 9; k++) begin
            drive(1'b1, $urandom_range(255), 1'($urandom_range(1)), 1'b0);
            checks++;
            if (out_valid !== (k == 9) || Y !== exp_y[9:0]) begin
                failures++;
                $display("FAIL flush_refill[%0d]: y=%0d vld=%0b, expected y=%0d vld=%0b", k, Y, out_valid, exp_y, (k == 9));
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 0, 1'b0, 1'b1);
        for (int k = 0; k < 14; k++) drive(1'b1, 10 + k, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        hist.delete();
        exp_y   = 0;
        exp_vld = 1'b0;
        checks++;
        if (Y !== 10'd0 || out_valid !== 1'b0 || dut.state_p0 !== FILL) begin
            failures++;
            $display("FAIL async_reset: y=%0d vld=%0b state=%0d, expected y=0 vld=0 state=FILL", Y, out_valid, dut.state_p0);
        end
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            drive(1'b1, $urandom_range(255), 1'b0, 1'b0);
            checks++;
            if (out_valid !== (k == 9) || Y !== exp_y[9:0]) begin
                failures++;
                $display("FAIL reset_refill[%0d]: y=%0d vld=%0b, expected y=%0d vld=%0b", k, Y, out_valid, exp_y, (k == 9));
            end
        end
    endtask

    task automatic test_nonint();
        drive(1'b0, 0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) drive(1'b1, 12, 1'b0, 1'b0);
        drive(1'b1, 13, 1'b0, 1'b0);
        checks++;
        if (Y !== 10'd27 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL nonint_avg: y=%0d vld=%0b, expected y=27 vld=1", Y, out_valid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(99) < 70, $urandom_range(255), 1'($urandom_range(1)),
                  $urandom_range(99) < 3);
            checks++;
            if (out_valid !== exp_vld || Y !== exp_y[9:0]) begin
                failures++;
                $display("FAIL random[%0d]: y=%0d vld=%0b, expected y=%0d vld=%0b", c, Y, out_valid, exp_y, exp_vld);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_run();
        test_bubbles();
        test_mode1_sat();
        test_flush();
        test_async_reset();
        test_nonint();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
